// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: widths, opcodes,
// flag bit positions and controller state encoding.
package alu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);
  localparam int unsigned INSTR_W  = 16;

  // Opcodes carried in instr[15:12]; also driven straight onto the ALU op bus.
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LDI   = 4'b0010;
  localparam logic [3:0] OP_HALT  = 4'b1110;
  localparam logic [3:0] OP_SHOWR = 4'b1111;

  // Bit positions inside flags_q = {CF, ZF, SF, OF}.
  localparam int unsigned FLAG_CF = 3;
  localparam int unsigned FLAG_ZF = 2;
  localparam int unsigned FLAG_SF = 1;
  localparam int unsigned FLAG_OF = 0;

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_WB     = 2'd2;
  localparam state_t ST_HALTED = 2'd3;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear to zero.
module alu_regfile #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Storage: cleared asynchronously, written on the rising edge when enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Instruction issue/writeback controller for a combinational 8-bit ALU.
// Accepts 16-bit instructions in IDLE, issues ADD/SHOWR to the ALU on the
// falling edge, writes back on the rising edge two edges after acceptance.
// Build option: define ALU_CTRL_HALT_EN to make opcode 1110 a sticky HALT;
// otherwise 1110 is treated as an illegal opcode.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_res,
  input  logic               alu_cf,
  input  logic               alu_zf,
  input  logic               alu_sf,
  input  logic               alu_of,
  output logic [3:0]         flags_q,
  output logic [DATA_W-1:0]  show_data,
  output logic               show_valid,
  output logic               busy,
  output logic               illegal
);

  state_t state_q, state_d;

  // Latched fields of the accepted instruction.
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q, rs_q;

  // Fields of the instruction currently offered.
  logic [3:0]        in_op;
  logic [REG_AW-1:0] in_rd, in_rs;
  logic [DATA_W-1:0] in_imm;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

  logic       accept;
  logic       illegal_d;
  logic       show_valid_d;
  logic       flags_we;
  logic [3:0] alu_flags;

  assign in_op  = instr[15:12];
  assign in_rd  = instr[11:10];
  assign in_rs  = instr[9:8];
  assign in_imm = instr[7:0];

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = ~instr_ready;
  assign accept      = instr_ready & instr_valid;

  // Pack ALU flags into the architectural flag layout.
  always_comb begin
    alu_flags          = '0;
    alu_flags[FLAG_CF] = alu_cf;
    alu_flags[FLAG_ZF] = alu_zf;
    alu_flags[FLAG_SF] = alu_sf;
    alu_flags[FLAG_OF] = alu_of;
  end

  alu_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .AW       (REG_AW)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .raddr_a (rd_q),
    .rdata_a (rf_rdata_a),
    .raddr_b (rs_q),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // Next-state, decode and writeback control.
  always_comb begin
    state_d      = state_q;
    rf_we        = 1'b0;
    rf_waddr     = rd_q;
    rf_wdata     = alu_res;
    illegal_d    = 1'b0;
    show_valid_d = 1'b0;
    flags_we     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          case (in_op)
            OP_NOP: ;
            OP_ADD, OP_SHOWR: state_d = ST_ISSUE;
            OP_LDI: begin
              // LDI bypasses the ALU and writes on the accepting edge.
              rf_we    = 1'b1;
              rf_waddr = in_rd;
              rf_wdata = in_imm;
            end
`ifdef ALU_CTRL_HALT_EN
            OP_HALT: state_d = ST_HALTED;
`endif
            default: illegal_d = 1'b1;
          endcase
        end
      end
      ST_ISSUE: state_d = ST_WB;
      ST_WB: begin
        state_d = ST_IDLE;
        // Only ADD and SHOWR ever reach writeback.
        if (op_q == OP_ADD) begin
          rf_we    = 1'b1;
          flags_we = 1'b1;
        end else begin
          show_valid_d = 1'b1;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Rising-edge state: FSM, instruction latch, flags, SHOWR output, pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      rd_q       <= '0;
      rs_q       <= '0;
      flags_q    <= '0;
      show_data  <= '0;
      show_valid <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      show_valid <= show_valid_d;
      illegal    <= illegal_d;
      if (accept) begin
        op_q <= in_op;
        rd_q <= in_rd;
        rs_q <= in_rs;
      end
      if (flags_we) begin
        flags_q <= alu_flags;
      end
      if (show_valid_d) begin
        show_data <= alu_res;
      end
    end
  end

  // Falling-edge ALU drive: operands are presented while clock is low so the
  // ALU settles before writeback samples it. Held through WB, then the op
  // drops to NOP so an identical next instruction re-triggers evaluation.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= OP_NOP;
    end else if (state_q == ST_ISSUE || state_q == ST_WB) begin
      alu_in1 <= rf_rdata_a;
      alu_in2 <= rf_rdata_b;
      alu_op  <= op_q;
    end else begin
      alu_op  <= OP_NOP;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, reset abort,
// randomized instruction stream against a register/flag model, HALT/1110 check.
module tb_alu_issue_ctrl;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_in1, alu_in2;
  logic [3:0]  alu_op;
  logic [7:0]  alu_res;
  logic        alu_cf, alu_zf, alu_sf, alu_of;
  logic [3:0]  flags_q;
  logic [7:0]  show_data;
  logic        show_valid;
  logic        busy;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_op      (alu_op),
    .alu_res     (alu_res),
    .alu_cf      (alu_cf),
    .alu_zf      (alu_zf),
    .alu_sf      (alu_sf),
    .alu_of      (alu_of),
    .flags_q     (flags_q),
    .show_data   (show_data),
    .show_valid  (show_valid),
    .busy        (busy),
    .illegal     (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU. Unused opcodes return junk so mistimed sampling shows up;
  // pass-through returns junk flags so flags latched on SHOWR show up.
  logic [8:0] sum9;
  always_comb begin
    sum9    = '0;
    alu_res = 8'hEE;
    {alu_cf, alu_zf, alu_sf, alu_of} = 4'b1111;
    if (alu_op == 4'b0001) begin
      sum9    = {1'b0, alu_in1} + {1'b0, alu_in2};
      alu_res = sum9[7:0];
      alu_cf  = sum9[8];
      alu_zf  = (sum9[7:0] == 8'h00);
      alu_sf  = sum9[7];
      alu_of  = (alu_in1[7] == alu_in2[7]) && (sum9[7] != alu_in1[7]);
    end else if (alu_op == 4'b1111) begin
      alu_res = alu_in1;
      {alu_cf, alu_zf, alu_sf, alu_of} = 4'b1011;
    end
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    bit r;
    r = !(op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hF);
`ifdef ALU_CTRL_HALT_EN
    if (op == 4'hE) r = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one instruction and follow it until the controller is idle again.
  task automatic run_instr(input logic [15:0] i, input bit noise, output bit sshow,
                           output logic [7:0] sdata, output bit sill, output int cyc);
    int guard;
    guard = 0;
    sshow = 1'b0;
    sdata = 8'h00;
    sill  = 1'b0;
    while (!instr_ready && guard < 20) begin
      @(posedge clock); #1; guard++;
    end
    if (!instr_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: instr_ready=%0b, expected 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr       = i;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    cyc = 1;
    sshow = show_valid; if (show_valid) sdata = show_data;
    sill  = illegal;
    while (!instr_ready && cyc < 12) begin
      if (noise) begin
        // Offers while busy must be ignored.
        instr_valid = 1'($urandom_range(0, 1));
        instr       = 16'($urandom);
      end
      @(posedge clock); #1;
      instr_valid = 1'b0;
      cyc++;
      sshow |= show_valid; if (show_valid) sdata = show_data;
      sill  |= illegal;
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  exp_flags;
    logic [7:0]  exp_show;
  } vec_t;

  vec_t tbl[19];

  logic [7:0] m_regs[4];
  logic [3:0] m_flags;

  initial begin
    bit         sshow, sill;
    logic [7:0] sdata;
    int         cyc;
    logic [3:0] op;

    reset_n = 1'b0; instr_valid = 1'b0; instr = '0;
    #12;
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", 32'(flags_q), 32'd0);
    chk("reset_show", 32'(show_data), 32'd0);
    chk("reset_pulses", 32'({show_valid, illegal}), 32'd0);
    chk("reset_aluop", 32'(alu_op), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed vectors: instruction, expected flags afterwards, SHOWR value.
    tbl[0]  = '{mk(4'h2, 0, 0, 8'h7F), 4'b0000, 8'h00};
    tbl[1]  = '{mk(4'h2, 1, 0, 8'h01), 4'b0000, 8'h00};
    tbl[2]  = '{mk(4'h1, 0, 1, 8'h00), 4'b0011, 8'h00};
    tbl[3]  = '{mk(4'hF, 0, 0, 8'h00), 4'b0011, 8'h80};
    tbl[4]  = '{mk(4'h2, 2, 0, 8'hFF), 4'b0011, 8'h00};
    tbl[5]  = '{mk(4'h2, 3, 0, 8'h01), 4'b0011, 8'h00};
    tbl[6]  = '{mk(4'h1, 2, 3, 8'h00), 4'b1100, 8'h00};
    tbl[7]  = '{mk(4'hF, 2, 0, 8'h00), 4'b1100, 8'h00};
    tbl[8]  = '{mk(4'h2, 0, 0, 8'h01), 4'b1100, 8'h00};
    tbl[9]  = '{mk(4'h2, 1, 0, 8'h01), 4'b1100, 8'h00};
    tbl[10] = '{mk(4'h1, 0, 1, 8'h00), 4'b0000, 8'h00};
    tbl[11] = '{mk(4'h1, 0, 1, 8'h00), 4'b0000, 8'h00};
    tbl[12] = '{mk(4'hF, 0, 0, 8'h00), 4'b0000, 8'h03};
    tbl[13] = '{mk(4'h2, 1, 0, 8'h5A), 4'b0000, 8'h00};
    tbl[14] = '{mk(4'hF, 1, 0, 8'h00), 4'b0000, 8'h5A};
    tbl[15] = '{mk(4'h5, 1, 0, 8'h00), 4'b0000, 8'h00};
    tbl[16] = '{mk(4'hF, 1, 0, 8'h00), 4'b0000, 8'h5A};
    tbl[17] = '{mk(4'h1, 3, 3, 8'h00), 4'b0000, 8'h00};
    tbl[18] = '{mk(4'hF, 3, 0, 8'h00), 4'b0000, 8'h02};

    for (int k = 0; k < 19; k++) begin
      op = tbl[k].ins[15:12];
      run_instr(tbl[k].ins, 1'b0, sshow, sdata, sill, cyc);
      chk($sformatf("vec%0d_cycles", k), 32'(cyc), (op == 4'h1 || op == 4'hF) ? 32'd3 : 32'd1);
      chk($sformatf("vec%0d_flags", k), 32'(flags_q), 32'(tbl[k].exp_flags));
      chk($sformatf("vec%0d_showv", k), 32'(sshow), 32'(op == 4'hF));
      if (op == 4'hF) chk($sformatf("vec%0d_show", k), 32'(sdata), 32'(tbl[k].exp_show));
      chk($sformatf("vec%0d_illegal", k), 32'(sill), 32'(is_illegal(op)));
      if (op == 4'h1 || op == 4'hF) begin
        @(negedge clock); #1;
        chk($sformatf("vec%0d_op_nop", k), 32'(alu_op), 32'd0);
      end
    end

    // Abort an ADD mid-ISSUE with an asynchronous reset.
    run_instr(mk(4'h2, 0, 0, 8'hFF), 1'b0, sshow, sdata, sill, cyc);
    run_instr(mk(4'h2, 1, 0, 8'h01), 1'b0, sshow, sdata, sill, cyc);
    run_instr(mk(4'h1, 0, 1, 8'h00), 1'b0, sshow, sdata, sill, cyc);
    chk("pre_abort_flags", 32'(flags_q), 32'b1100);
    instr_valid = 1'b1; instr = mk(4'h1, 1, 1, 8'h00);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    @(negedge clock); #1;
    chk("abort_aluop_issue", 32'(alu_op), 32'h1);
    reset_n = 1'b0; #1;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_flags", 32'(flags_q), 32'd0);
    chk("abort_aluop", 32'(alu_op), 32'd0);
    chk("abort_in1", 32'(alu_in1), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    for (int r = 0; r < 4; r++) begin
      run_instr(mk(4'hF, 2'(r), 0, 8'h00), 1'b0, sshow, sdata, sill, cyc);
      chk($sformatf("abort_reg%0d", r), 32'({sshow, sdata}), 32'h100);
    end
    chk("abort_flags_after", 32'(flags_q), 32'd0);

    // Randomized stream against the register/flag model.
    for (int r = 0; r < 4; r++) m_regs[r] = 8'h00;
    m_flags = 4'b0000;
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  rd, rs;
      logic [7:0]  imm, a, b, s;
      logic [8:0]  wide;
      int          sel;
      bit          exp_show;
      sel = $urandom_range(0, 9);
      rd  = 2'($urandom); rs = 2'($urandom); imm = 8'($urandom);
      case (sel)
        0:       op = 4'h0;
        1, 2, 3: op = 4'h1;
        4, 5, 6: op = 4'h2;
        7, 8:    op = 4'hF;
        default: op = 4'($urandom_range(3, 13));
      endcase
      exp_show = 1'b0;
      run_instr(mk(op, rd, rs, imm), 1'b1, sshow, sdata, sill, cyc);
      if (op == 4'h1) begin
        a = m_regs[rd]; b = m_regs[rs];
        wide = {1'b0, a} + {1'b0, b};
        s = wide[7:0];
        m_regs[rd] = s;
        m_flags = {wide[8], s == 8'h00, s[7], (a[7] == b[7]) && (s[7] != a[7])};
      end else if (op == 4'h2) begin
        m_regs[rd] = imm;
      end else if (op == 4'hF) begin
        exp_show = 1'b1;
        chk($sformatf("rnd%0d_show", n), 32'(sdata), 32'(m_regs[rd]));
      end
      chk($sformatf("rnd%0d_flags", n), 32'(flags_q), 32'(m_flags));
      chk($sformatf("rnd%0d_showv", n), 32'(sshow), 32'(exp_show));
      chk($sformatf("rnd%0d_illegal", n), 32'(sill), 32'(is_illegal(op)));
      chk($sformatf("rnd%0d_cycles", n), 32'(cyc), (op == 4'h1 || op == 4'hF) ? 32'd3 : 32'd1);
    end

`ifdef ALU_CTRL_HALT_EN
    // HALT is sticky until reset, ALU stays at NOP, offers are ignored.
    instr_valid = 1'b1; instr = mk(4'hE, 0, 0, 8'h00);
    @(posedge clock); #1;
    instr = mk(4'h2, 0, 0, 8'h33);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      chk($sformatf("halt%0d_ready", c), 32'({instr_ready, busy}), 32'b01);
      chk($sformatf("halt%0d_aluop", c), 32'(alu_op), 32'd0);
    end
    instr_valid = 1'b0;
    reset_n = 1'b0; #1;
    chk("halt_reset_ready", 32'(instr_ready), 32'd1);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    run_instr(mk(4'hF, 0, 0, 8'h00), 1'b0, sshow, sdata, sill, cyc);
    chk("halt_reg0", 32'({sshow, sdata}), 32'h100);
`else
    // Without the HALT option, 1110 is just another illegal opcode.
    run_instr(mk(4'hE, 0, 0, 8'h44), 1'b0, sshow, sdata, sill, cyc);
    chk("op1110_illegal", 32'(sill), 32'd1);
    chk("op1110_cycles", 32'(cyc), 32'd1);
    chk("op1110_flags", 32'(flags_q), 32'(m_flags));
    run_instr(mk(4'hF, 0, 0, 8'h00), 1'b0, sshow, sdata, sill, cyc);
    chk("op1110_reg0", 32'(sdata), 32'(m_regs[0]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected done", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction issue and writeback controller that drives the combinational 8-bit ALU's in1/in2/op inputs and consumes its res/CF/ZF/SF/OF outputs. It accepts 16-bit instructions over a valid/ready handshake and owns a small register file. It sequences each instruction through issue and writeback, and latches the architectural flags. It sits between instruction fetch and the ALU.

Parameters:
DATA_W, 8, operand/register width; must match ALU width
NUM_REGS, 4, register file depth; REG_AW = clog2(NUM_REGS) = 2
INSTR_W, 16, instruction width

Ports:
clock  input  1  single system clock
reset_n  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction offered
instr  input  16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
instr_ready  output  1  controller can accept; high only in IDLE
alu_in1  output  8  ALU operand 1
alu_in2  output  8  ALU operand 2
alu_op  output  4  ALU opcode
alu_res  input  8  ALU result
alu_cf, alu_zf, alu_sf, alu_of  input  1 each  ALU flags
flags_q  output  4  latched {CF,ZF,SF,OF}
show_data  output  8  SHOWR result
show_valid  output  1  one-cycle pulse when show_data updates
busy  output  1  high when not IDLE
illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, reset_n low): state=IDLE; regs, alu_in1, alu_in2, show_data=0; alu_op=NOP(0000); flags_q=0; show_valid, illegal=0.
- Opcodes:
  - 0000 NOP
  - 0001 ADD: rd <= rd+rs
  - 0010 LDI: rd <= imm; no ALU use
  - 1111 SHOWR: show_data <= rd via ALU pass-through
  - All other opcodes are illegal.
- FSM states: IDLE, ISSUE, WB.
  - IDLE: instr_ready=1. On a rising edge with instr_valid, latch instr.
  - Next state from IDLE: ADD/SHOWR -> ISSUE. LDI writes rd on the same edge and stays in IDLE. NOP stays in IDLE. Illegal pulses illegal and stays in IDLE.
  - ISSUE: alu_in1=reg[rd], alu_in2=reg[rs], alu_op=instr op. These outputs update on the FALLING clock edge, so the ALU evaluates while clock is low. ISSUE->WB on the next rising edge.
  - WB: on the rising edge, sample alu_res and the flags.
    - ADD: reg[rd] <= alu_res; flags_q <= {cf,zf,sf,of}.
    - SHOWR: show_data <= alu_res; pulse show_valid; flags_q unchanged.
    - Then go to IDLE. alu_op returns to NOP on the following falling edge, so an identical back-to-back instruction retriggers ALU evaluation.
- Latency: ADD/SHOWR accept-to-writeback is 2 rising edges, for a throughput of one instruction per 3 cycles. LDI/NOP take 1 cycle.
- instr_valid while busy is ignored; the producer must hold instr until instr_ready is high.
- ADD with rd==rs doubles the register; the result is still defined.
- Reset mid-ISSUE/WB: the instruction is aborted, with no writeback and no flag change.
- Flags are not modified by LDI, NOP, SHOWR or illegal opcodes.

Optional Feature:
ALU_CTRL_HALT_EN.
- Defined: opcode 1110 = HALT. It enters the HALTED state: instr_ready=0, busy=1, alu_op held at NOP. Only reset_n exits HALTED.
- Undefined: 1110 is illegal, the same as other undefined opcodes.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants: OP_NOP, OP_ADD, OP_LDI, OP_HALT, OP_SHOWR.
  - Flag bit indices: FLAG_CF=3, FLAG_ZF=2, FLAG_SF=1, FLAG_OF=0.
  - The state enum.
  - DATA_W.
- One sub-module: alu_regfile (NUM_REGS x DATA_W, two async read ports, one sync write port, async clear).

Test Plan:
- Sequence: LDI r0,0x7F; LDI r1,0x01; ADD r0,r1 -> r0=0x80, flags_q=0011 (CF0 ZF0 SF1 OF1).
- LDI r2,0xFF; LDI r3,0x01; ADD r2,r3 -> r2=0x00, flags_q=1100.
- Two consecutive identical ADD r0,r1 (r0=1, r1=1) -> r0=2 then 3; alu_op observed returning to 0000 between the two issues.
- LDI r1,0x5A; SHOWR r1 -> show_data=0x5A with a one-cycle show_valid; flags_q unchanged.
- reset_n low during ISSUE of ADD -> all regs 0, flags_q=0, state IDLE, instr_ready=1 immediately (async).
- Opcode 0101 -> one-cycle illegal pulse, no register/flag change. With ALU_CTRL_HALT_EN, opcode 1110 -> instr_ready stuck at 0 until reset.
